// File: rtl/div_pkg.sv
// Shared types and sizing helpers for the iterative restoring divider.
package div_pkg;

  localparam int unsigned DIV_WIDTH_DEFAULT = 16;

  typedef enum logic {
    IDLE = 1'b0,
    CALC = 1'b1
  } state_e;

  // Iteration counter width; clamped so a 2-bit divider still gets a 1-bit counter.
  function automatic int unsigned div_cnt_width(input int unsigned width);
    return (width <= 2) ? 1 : $clog2(width);
  endfunction

endpackage : div_pkg

// File: rtl/seq_divider_if.sv
// Start/busy/done handshake and operand/result bus of the sequential divider.
interface seq_divider_if
  import div_pkg::*;
#(
  parameter int unsigned WIDTH = DIV_WIDTH_DEFAULT
);

  logic             start;
  logic [WIDTH-1:0] dividend;
  logic [WIDTH-1:0] divisor;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] quotient;
  logic [WIDTH-1:0] remainder;
  logic             div_by_zero;

  modport master (
    output start, dividend, divisor,
    input  busy, done, quotient, remainder, div_by_zero
  );

  modport slave (
    input  start, dividend, divisor,
    output busy, done, quotient, remainder, div_by_zero
  );

endinterface : seq_divider_if

// File: rtl/div_step.sv
// One restoring-division iteration: shift in a dividend bit, trial-subtract, restore on borrow.
module div_step
  import div_pkg::*;
#(
  parameter int unsigned WIDTH = DIV_WIDTH_DEFAULT
) (
  input  logic [WIDTH-1:0] rem_i,
  input  logic             bit_i,
  input  logic [WIDTH-1:0] divisor_i,
  output logic [WIDTH-1:0] rem_o,
  output logic             q_bit_o
);

  logic [WIDTH:0]   shifted;
  logic [WIDTH+1:0] trial;
  logic             borrow;

  // Extra top bit of the trial difference is the borrow-out of the WIDTH+1-bit subtract.
  always_comb begin
    shifted = {rem_i, bit_i};
    trial   = {1'b0, shifted} - {2'b00, divisor_i};
    borrow  = trial[WIDTH+1];
    q_bit_o = ~borrow;
    rem_o   = borrow ? shifted[WIDTH-1:0] : trial[WIDTH-1:0];
  end

endmodule : div_step

// File: rtl/seq_divider.sv
// Iterative unsigned restoring divider; one quotient bit per clock with a start/busy/done handshake.
module seq_divider
  import div_pkg::*;
#(
  parameter int unsigned WIDTH = DIV_WIDTH_DEFAULT
) (
  input  logic         clk,
  input  logic         rst_n,
  seq_divider_if.slave bus
);

  localparam int unsigned CNT_W = div_cnt_width(WIDTH);

  state_e           state_q, state_d;
  logic [WIDTH-1:0] rem_q, rem_d;
  logic [WIDTH-1:0] shift_q, shift_d;
  logic [WIDTH-1:0] divisor_q, divisor_d;
  logic [WIDTH-1:0] quotient_q, quotient_d;
  logic [WIDTH-1:0] remainder_q, remainder_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             dbz_q, dbz_d;
  logic             dbz_pend_q, dbz_pend_d;

  logic [WIDTH-1:0] step_rem;
  logic             step_bit;

  div_step #(.WIDTH(WIDTH)) u_step (
    .rem_i     (rem_q),
    .bit_i     (shift_q[WIDTH-1]),
    .divisor_i (divisor_q),
    .rem_o     (step_rem),
    .q_bit_o   (step_bit)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      rem_q       <= '0;
      shift_q     <= '0;
      divisor_q   <= '0;
      quotient_q  <= '0;
      remainder_q <= '0;
      cnt_q       <= '0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      dbz_q       <= 1'b0;
      dbz_pend_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      rem_q       <= rem_d;
      shift_q     <= shift_d;
      divisor_q   <= divisor_d;
      quotient_q  <= quotient_d;
      remainder_q <= remainder_d;
      cnt_q       <= cnt_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      dbz_q       <= dbz_d;
      dbz_pend_q  <= dbz_pend_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (bus.start && (bus.divisor != '0)) state_d = CALC;
      CALC:    if (cnt_q == '0) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Datapath and output register updates; a zero divisor is resolved in IDLE one cycle later.
  always_comb begin
    rem_d       = rem_q;
    shift_d     = shift_q;
    divisor_d   = divisor_q;
    quotient_d  = quotient_q;
    remainder_d = remainder_q;
    cnt_d       = cnt_q;
    busy_d      = busy_q;
    done_d      = 1'b0;
    dbz_d       = dbz_q;
    dbz_pend_d  = 1'b0;

    case (state_q)
      IDLE: begin
        if (dbz_pend_q) begin
          done_d      = 1'b1;
          dbz_d       = 1'b1;
          quotient_d  = '1;
          remainder_d = shift_q;
        end
        if (bus.start) begin
          shift_d = bus.dividend;
          if (bus.divisor != '0) begin
            rem_d     = '0;
            divisor_d = bus.divisor;
            cnt_d     = CNT_W'(WIDTH - 1);
            busy_d    = 1'b1;
          end else begin
            dbz_pend_d = 1'b1;
          end
        end
      end
      CALC: begin
        rem_d   = step_rem;
        shift_d = {shift_q[WIDTH-2:0], step_bit};
        if (cnt_q == '0) begin
          quotient_d  = {shift_q[WIDTH-2:0], step_bit};
          remainder_d = step_rem;
          done_d      = 1'b1;
          dbz_d       = 1'b0;
          busy_d      = 1'b0;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      default: ;
    endcase
  end

  assign bus.busy        = busy_q;
  assign bus.done        = done_q;
  assign bus.quotient    = quotient_q;
  assign bus.remainder   = remainder_q;
  assign bus.div_by_zero = dbz_q;

endmodule : seq_divider

// File: tb/tb_seq_divider.sv
// Randomized self-checking bench for seq_divider against a plain-arithmetic reference.
module tb_seq_divider;

  localparam int unsigned W = 16;

  logic clk;
  logic rst_n;

  seq_divider_if #(.WIDTH(W)) bus ();

  seq_divider #(.WIDTH(W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int errors   = 0;
  int checks   = 0;
  int done_cnt = 0;
  int accepted = 0;

  always @(negedge clk) if (bus.done === 1'b1) done_cnt++;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Issue one divide and check latency, busy window and results; ign* are sample
  // indices at which a stray start pulse is driven while the op is in flight.
  task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b,
                        input int ign1, input int ign2);
    int lat, busy_cnt, exp_lat, exp_busy;
    logic [W-1:0] eq, er;
    bit dz;
    dz       = (b == 0);
    eq       = dz ? {W{1'b1}} : a / b;
    er       = dz ? a : a % b;
    exp_lat  = dz ? 1 : W;
    exp_busy = dz ? 0 : W;

    bus.start    = 1'b1;
    bus.dividend = a;
    bus.divisor  = b;
    @(posedge clk); #1;
    accepted++;
    bus.start    = 1'b0;
    bus.dividend = W'($urandom);
    bus.divisor  = W'($urandom);

    lat = 0; busy_cnt = 0;
    while (bus.done !== 1'b1 && lat < 40) begin
      if (bus.busy === 1'b1) busy_cnt++;
      bus.start = (lat == ign1 || lat == ign2);
      if (bus.start) begin
        bus.dividend = W'($urandom);
        bus.divisor  = W'($urandom_range(1, 65535));
      end
      @(posedge clk); #1;
      lat++;
    end
    bus.start = 1'b0;

    check("done_seen", 32'(bus.done), 32'(1));
    check("latency",   32'(lat), 32'(exp_lat));
    check("busy_cycles", 32'(busy_cnt), 32'(exp_busy));
    check("busy_at_done", 32'(bus.busy), 32'(0));
    check("quotient",  32'(bus.quotient), 32'(eq));
    check("remainder", 32'(bus.remainder), 32'(er));
    check("div_by_zero", 32'(bus.div_by_zero), 32'(dz));
  endtask

  initial begin
    logic [W-1:0] ra, rb;
    int sel;

    rst_n        = 1'b0;
    bus.start    = 1'b0;
    bus.dividend = '0;
    bus.divisor  = '0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_busy", 32'(bus.busy), 32'(0));
    check("rst_done", 32'(bus.done), 32'(0));
    check("rst_q",    32'(bus.quotient), 32'(0));
    check("rst_r",    32'(bus.remainder), 32'(0));
    check("rst_dbz",  32'(bus.div_by_zero), 32'(0));
    @(negedge clk) rst_n = 1'b1;
    @(negedge clk);

    run_op(16'd100, 16'd7, -1, -1);
    run_op(16'hFFFF, 16'hFFFF, -1, -1);
    run_op(16'hFFFF, 16'd1, -1, -1);
    run_op(16'd3, 16'd10, -1, -1);
    run_op(16'd5, 16'd0, -1, -1);
    @(negedge clk);
    // stray starts mid-operation, then a start issued in the done cycle
    run_op(16'd100, 16'd7, 3, 8);
    run_op(16'd50, 16'd5, -1, -1);

    // abort at iteration 8
    bus.start = 1'b1; bus.dividend = 16'd40000; bus.divisor = 16'd3;
    @(posedge clk); #1;
    bus.start = 1'b0;
    repeat (8) @(posedge clk);
    #1 rst_n = 1'b0;
    #1;
    check("abort_busy", 32'(bus.busy), 32'(0));
    check("abort_done", 32'(bus.done), 32'(0));
    check("abort_q",    32'(bus.quotient), 32'(0));
    check("abort_r",    32'(bus.remainder), 32'(0));
    check("abort_dbz",  32'(bus.div_by_zero), 32'(0));
    @(negedge clk) rst_n = 1'b1;
    @(negedge clk);
    run_op(16'd1000, 16'd33, -1, -1);

    for (int i = 0; i < 3000; i++) begin
      sel = int'($urandom_range(0, 9));
      ra  = W'($urandom);
      case (sel)
        0:       rb = '0;
        1, 2:    rb = W'($urandom_range(1, 15));
        3:       rb = 16'hFFFF;
        4:       begin rb = W'($urandom); ra = W'($urandom_range(0, 255)); end
        default: rb = W'($urandom);
      endcase
      run_op(ra, rb, -1, -1);
      if ($urandom_range(0, 3) == 0) @(negedge clk);
    end

    @(negedge clk);
    @(negedge clk);
    check("done_count", 32'(done_cnt), 32'(accepted));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule : tb_seq_divider
